add4_serial_ctrl: RTL and testbench
===================================

# add4_serial_ctrl

Sequencer that performs a wide addition (NIBBLES×4 bits plus carry-in) by time-multiplexing a single `add4` nibble adder. Carry propagation between nibbles is handled in a second `add4` pass per nibble, because `add4` has no carry-in. The block sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It owns the only `add4` instance in the wide-add path.

## Interface
- NIBBLES, default 4: operand width in nibbles (W = 4×NIBBLES). Legal range 1–16.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands presented
- in_ready  output  1  block idle and able to accept
- in_a  input  W  operand A
- in_b  input  W  operand B
- in_cin  input  1  carry into nibble 0
- out_valid  output  1  result held and valid
- out_ready  input  1  consumer accepts the result
- out_sum  output  W  A + B + cin, modulo 2^W
- out_cout  output  1  carry out of the top nibble

## Operation
- States:
  - IDLE: in_ready=1. On in_valid && in_ready: capture in_a, in_b and in_cin (into carry register cy); set idx=0; go to ADD.
  - ADD: add4 A = a[idx], B = b[idx]. Register tmp ← S and c1 ← C. Go to CINC.
  - CINC: add4 A = tmp, B = {3'b0, cy}. Write sum[idx] ← S and cy ← c1 | C.
    - If idx == NIBBLES−1: go to DONE.
    - Otherwise: idx ← idx+1 and go to ADD.
  - DONE: out_valid=1, out_sum=sum, out_cout=cy. On out_ready: go to IDLE.
- c1 and the CINC-pass carry are never both 1, so OR is exact.
- The CINC pass always executes, even when cy=0. Latency is fixed and data-independent.
- While the block is not in IDLE, in_valid is ignored and in_a/in_b/in_cin may change freely; the captured operands are used.
- Output values are held stable while out_valid=1 && !out_ready.
- idx width is clog2(NIBBLES), minimum 1. idx never wraps; the terminal compare is against NIBBLES−1.
- Reset mid-operation: the operation is aborted and no result is produced.

## Timing
- Reset values: in_ready=1, out_valid=0, out_sum=0, out_cout=0. State=IDLE, idx=0, cy=0.
- Accept edge = T0. out_valid rises after edge T0 + 2×NIBBLES. Example: NIBBLES=4 gives 8 cycles.
- The result handshake completes at the edge where out_valid && out_ready. in_ready=1 from the next cycle.
- Throughput: one operation per 2×NIBBLES + 2 cycles with out_ready tied high. There is no combinational path from out_ready to in_ready.
- All outputs are registered or decoded from state only. No input-to-output combinational paths.
- rst_n assertion clears all state asynchronously. Deassertion is synchronised externally.

## Structure
- Shared package `add4_pkg`:
  - NIBBLE_W = 4
  - enum typedef `add4_seq_state_t` {IDLE, ADD, CINC, DONE}
  - function `idx_w(n)` returning max(1, clog2(n))
- One sub-module: a single `add4` instance. Its A/B inputs are muxed by state: (a[idx], b[idx]) in ADD, (tmp, {3'b0,cy}) in CINC.
- Operand and sum storage are W-bit registers with nibble-indexed part-selects. No RAM.

## Test plan
- NIBBLES=4: in_a=0xFFFF, in_b=0x0001, cin=0, out_ready=1 → out_sum=0x0000, out_cout=1. out_valid rises exactly 8 cycles after accept.
- NIBBLES=4: in_a=0x1234, in_b=0x4321, cin=1 → out_sum=0x5556, out_cout=0. in_ready=0 throughout, and a second in_valid pulse mid-operation is not accepted.
- Backpressure: in_a=0x8000, in_b=0x8000, cin=0, out_ready=0 for 5 cycles after out_valid → out_sum=0x0000 and out_cout=1 held stable. in_ready returns 1 the cycle after out_ready is asserted.
- Reset mid-operation: assert rst_n=0 four cycles after accepting 0xAAAA+0x5555 → out_valid=0, in_ready=1 and out_sum=0 immediately. The next operation 0x0003+0x0004 → 0x0007.
- NIBBLES=1: in_a=0xF, in_b=0xF, cin=1 → out_sum=0xF, out_cout=1 after 2 cycles. NIBBLES=16: all-ones + 0 with cin=1 → sum 0, cout 1 after 32 cycles.
- Back-to-back with in_valid and out_ready held high: a random sweep of 1000 vectors matches the reference A+B+cin. Accepts are spaced exactly 2×NIBBLES+2 cycles apart.

Source files
------------

// File: rtl/add4_pkg.sv
// Shared definitions for the serial wide-add sequencer and its nibble adder.
package add4_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        CINC,
        DONE
    } add4_seq_state_t;

    // Nibble-index width: clog2(n), but never less than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/add4.sv
// Four-bit adder without carry-in; carry out of bit 3 is reported on c.
module add4
    import add4_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    output logic [NIBBLE_W-1:0] s,
    output logic                c
);

    // Plain five-bit sum split into carry and nibble.
    always_comb begin
        {c, s} = {1'b0, a} + {1'b0, b};
    end

endmodule

// File: rtl/add4_serial_ctrl.sv
// Wide adder built from one shared add4, two passes per nibble:
// ADD forms a[idx]+b[idx], CINC folds in the running carry.
module add4_serial_ctrl
    import add4_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NIBBLES*NIBBLE_W-1:0]   in_a,
    input  logic [NIBBLES*NIBBLE_W-1:0]   in_b,
    input  logic                          in_cin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NIBBLES*NIBBLE_W-1:0]   out_sum,
    output logic                          out_cout
);

    localparam int unsigned W        = NIBBLES * NIBBLE_W;
    localparam int unsigned IDX_W    = idx_w(NIBBLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    add4_seq_state_t state, state_next;

    logic [W-1:0]        a_reg;
    logic [W-1:0]        b_reg;
    logic [W-1:0]        sum_reg;
    logic [NIBBLE_W-1:0] tmp;
    logic                c1;
    logic                cy;
    logic [IDX_W-1:0]    idx;
    logic                last;

    logic [NIBBLE_W-1:0] add_a;
    logic [NIBBLE_W-1:0] add_b;
    logic [NIBBLE_W-1:0] add_s;
    logic                add_c;

    assign last = (idx == IDX_LAST);

    add4 u_add4 (
        .a (add_a),
        .b (add_b),
        .s (add_s),
        .c (add_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and adder operand mux.
    always_comb begin
        state_next = state;
        add_a      = '0;
        add_b      = '0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = ADD;
                end
            end
            ADD: begin
                add_a      = a_reg[idx*NIBBLE_W +: NIBBLE_W];
                add_b      = b_reg[idx*NIBBLE_W +: NIBBLE_W];
                state_next = CINC;
            end
            CINC: begin
                add_a      = tmp;
                add_b      = {{(NIBBLE_W-1){1'b0}}, cy};
                state_next = last ? DONE : ADD;
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, per-nibble partial results and carry chaining.
    // c1 and the CINC carry are mutually exclusive, so OR is an exact add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
            tmp     <= '0;
            c1      <= 1'b0;
            cy      <= 1'b0;
            idx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= in_a;
                        b_reg <= in_b;
                        cy    <= in_cin;
                        idx   <= '0;
                    end
                end
                ADD: begin
                    tmp <= add_s;
                    c1  <= add_c;
                end
                CINC: begin
                    sum_reg[idx*NIBBLE_W +: NIBBLE_W] <= add_s;
                    cy <= c1 | add_c;
                    if (!last) begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake flags decode from state; result comes straight from registers.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        out_sum   = sum_reg;
        out_cout  = cy;
    end

endmodule

// File: tb/tb_add4_serial_ctrl.sv
// Self-checking bench for add4_serial_ctrl at NIBBLES = 4, 1 and 16.
module tb_add4_serial_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // NIBBLES = 4 instance
    logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout;
    logic [15:0] in_a, in_b, out_sum;

    // NIBBLES = 1 instance
    logic        n1_in_valid, n1_in_ready, n1_in_cin, n1_out_valid, n1_out_ready, n1_out_cout;
    logic [3:0]  n1_in_a, n1_in_b, n1_out_sum;

    // NIBBLES = 16 instance
    logic        n16_in_valid, n16_in_ready, n16_in_cin, n16_out_valid, n16_out_ready, n16_out_cout;
    logic [63:0] n16_in_a, n16_in_b, n16_out_sum;

    int n_cmp = 0;
    int n_bad = 0;

    add4_serial_ctrl #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout)
    );

    add4_serial_ctrl #(.NIBBLES(1)) dut_n1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(n1_in_valid), .in_ready(n1_in_ready),
        .in_a(n1_in_a), .in_b(n1_in_b), .in_cin(n1_in_cin),
        .out_valid(n1_out_valid), .out_ready(n1_out_ready),
        .out_sum(n1_out_sum), .out_cout(n1_out_cout)
    );

    add4_serial_ctrl #(.NIBBLES(16)) dut_n16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(n16_in_valid), .in_ready(n16_in_ready),
        .in_a(n16_in_a), .in_b(n16_in_b), .in_cin(n16_in_cin),
        .out_valid(n16_out_valid), .out_ready(n16_out_ready),
        .out_sum(n16_out_sum), .out_cout(n16_out_cout)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        int unsigned hold;   // cycles of out_ready=0 after out_valid rises
        bit          pulse;  // spurious in_valid pulse while busy
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One NIBBLES=4 transaction; called at a sample point (#1 after posedge).
    task automatic run4(input vec_t v, input string tag);
        int cyc;
        bit ready_bad;
        chk($sformatf("%s_idle_ready", tag), in_ready, 1);
        in_a      = v.a;
        in_b      = v.b;
        in_cin    = v.cin;
        in_valid  = 1'b1;
        out_ready = (v.hold == 0);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_a      = 16'hDEAD;
        in_b      = 16'hBEEF;
        in_cin    = ~v.cin;
        cyc       = 0;
        ready_bad = 1'b0;
        while (!out_valid && cyc < 200) begin
            if (in_ready) ready_bad = 1'b1;
            if (v.pulse && cyc == 3) in_valid = 1'b1;
            if (v.pulse && cyc == 4) in_valid = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        chk($sformatf("%s_latency", tag), cyc, 8);
        chk($sformatf("%s_busy_ready_low", tag), ready_bad, 0);
        chk($sformatf("%s_sum", tag), out_sum, v.sum);
        chk($sformatf("%s_cout", tag), out_cout, v.cout);
        if (v.hold > 0) begin
            repeat (v.hold) begin
                @(posedge clk); #1;
                chk($sformatf("%s_hold_valid", tag), out_valid, 1);
                chk($sformatf("%s_hold_ready", tag), in_ready, 0);
                chk($sformatf("%s_hold_sum", tag), out_sum, v.sum);
                chk($sformatf("%s_hold_cout", tag), out_cout, v.cout);
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk($sformatf("%s_after_ready", tag), in_ready, 1);
        chk($sformatf("%s_after_valid", tag), out_valid, 0);
    endtask

    task automatic run1(input logic [3:0] a, input logic [3:0] b, input logic cin);
        logic [4:0] expv;
        int cyc;
        expv = 5'(a) + 5'(b) + 5'(cin);
        n1_in_a = a; n1_in_b = b; n1_in_cin = cin; n1_in_valid = 1'b1;
        @(posedge clk); #1;
        n1_in_valid = 1'b0;
        cyc = 0;
        while (!n1_out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("n1_latency", cyc, 2);
        chk("n1_sum", n1_out_sum, expv[3:0]);
        chk("n1_cout", n1_out_cout, expv[4]);
        @(posedge clk); #1;
        chk("n1_after_ready", n1_in_ready, 1);
    endtask

    task automatic run16(input logic [63:0] a, input logic [63:0] b, input logic cin);
        logic [64:0] expv;
        int cyc;
        expv = 65'(a) + 65'(b) + 65'(cin);
        n16_in_a = a; n16_in_b = b; n16_in_cin = cin; n16_in_valid = 1'b1;
        @(posedge clk); #1;
        n16_in_valid = 1'b0;
        cyc = 0;
        while (!n16_out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("n16_latency", cyc, 32);
        chk("n16_sum", n16_out_sum, expv[63:0]);
        chk("n16_cout", n16_out_cout, expv[64]);
        @(posedge clk); #1;
        chk("n16_after_ready", n16_in_ready, 1);
    endtask

    initial begin
        logic [16:0] q[$];
        logic [16:0] e;
        int          cyc;
        int          acc_cnt;
        int          last_acc;
        bit          renew;
        vec_t        rv;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0, 1'b0};
        vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 0, 1'b1};
        vecs[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 5, 1'b0};
        vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 0, 1'b0};
        vecs[4] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 0, 1'b0};
        vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 0, 1'b0};
        vecs[6] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 2, 1'b1};

        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
        n1_in_valid = 1'b0; n1_in_a = '0; n1_in_b = '0; n1_in_cin = 1'b0; n1_out_ready = 1'b1;
        n16_in_valid = 1'b0; n16_in_a = '0; n16_in_b = '0; n16_in_cin = 1'b0; n16_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_cout", out_cout, 0);
        chk("rst_n1_in_ready", n1_in_ready, 1);
        chk("rst_n16_out_valid", n16_out_valid, 0);

        for (int i = 0; i < $size(vecs); i++) begin
            run4(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset four cycles into 0xAAAA + 0x5555 aborts it cleanly.
        in_a = 16'hAAAA; in_b = 16'h5555; in_cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_sum", out_sum, 0);
        chk("midrst_out_cout", out_cout, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_idle_valid", out_valid, 0);
        rv = '{16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 0, 1'b0};
        run4(rv, "post_rst");

        run1(4'hF, 4'hF, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run1(4'($urandom), 4'($urandom), 1'($urandom));
        end

        run16('1, '0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run16({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
        end

        // Back-to-back sweep with in_valid and out_ready held high.
        out_ready = 1'b1;
        in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
        in_valid = 1'b1;
        cyc = 0; acc_cnt = 0; last_acc = -1;
        while ((acc_cnt < 1000 || q.size() > 0) && cyc < 20000) begin
            renew = 1'b0;
            if (in_valid && in_ready) begin
                q.push_back(17'(in_a) + 17'(in_b) + 17'(in_cin));
                if (last_acc >= 0) chk("b2b_spacing", cyc - last_acc, 10);
                last_acc = cyc;
                acc_cnt++;
                renew = 1'b1;
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("b2b_spurious_valid", out_valid, 0);
                end else begin
                    e = q.pop_front();
                    chk("b2b_sum", out_sum, e[15:0]);
                    chk("b2b_cout", out_cout, e[16]);
                end
            end
            @(posedge clk); #1;
            cyc++;
            if (renew) begin
                if (acc_cnt < 1000) begin
                    in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("b2b_completed", cyc < 20000, 1);
        chk("b2b_accepts", acc_cnt, 1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
